// File: rtl/rgb_fade_ctrl.sv
// RGB duty sequencer feeding three PWM drivers: accepts a target colour and either
// loads it at once or fades each channel toward it by at most STEP every TICK_DIV clocks.
module rgb_fade_ctrl #(
  parameter int TICK_DIV = 256,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  input  logic       fade_en,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [8:0]       STEP_9   = 9'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       duty_r_q, duty_g_q, duty_b_q;
  logic [7:0]       duty_r_d, duty_g_d, duty_b_d;
  logic [7:0]       tgt_r_q, tgt_g_q, tgt_b_q;
  logic [7:0]       tgt_r_d, tgt_g_d, tgt_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [7:0]       nxt_r, nxt_g, nxt_b;
  logic             accept;
  logic             already_there;
  logic             step_edge;
  logic             fade_complete;

  // Moves cur toward tgt by at most STEP; 9-bit differences keep it from wrapping or overshooting.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] diff;
    logic [8:0] res;
    diff = 9'd0;
    res  = {1'b0, cur};
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = {1'b0, cur} + ((diff > STEP_9) ? STEP_9 : diff);
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = {1'b0, cur} - ((diff > STEP_9) ? STEP_9 : diff);
    end
    return res[7:0];
  endfunction

  assign tgt_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q == FADE);
  assign done      = done_q;
  assign duty_r    = duty_r_q;
  assign duty_g    = duty_g_q;
  assign duty_b    = duty_b_q;

  assign accept        = tgt_valid && tgt_ready;
  assign already_there = (tgt_r == duty_r_q) && (tgt_g == duty_g_q) && (tgt_b == duty_b_q);
  assign step_edge     = (cnt_q == CNT_LAST);

  assign nxt_r = step_toward(duty_r_q, tgt_r_q);
  assign nxt_g = step_toward(duty_g_q, tgt_g_q);
  assign nxt_b = step_toward(duty_b_q, tgt_b_q);

  assign fade_complete = (nxt_r == tgt_r_q) && (nxt_g == tgt_g_q) && (nxt_b == tgt_b_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    tgt_r_d  = tgt_r_q;
    tgt_g_d  = tgt_g_q;
    tgt_b_d  = tgt_b_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_r_d = tgt_r;
          tgt_g_d = tgt_g;
          tgt_b_d = tgt_b;
          // A fade to the colour already shown collapses into an immediate load.
          if (!fade_en || already_there) begin
            duty_r_d = tgt_r;
            duty_g_d = tgt_g;
            duty_b_d = tgt_b;
            done_d   = 1'b1;
          end else begin
            state_d = FADE;
            cnt_d   = '0;
          end
        end
      end
      FADE: begin
        if (step_edge) begin
          cnt_d    = '0;
          duty_r_d = nxt_r;
          duty_g_d = nxt_g;
          duty_b_d = nxt_b;
          if (fade_complete) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      duty_r_q <= 8'd0;
      duty_g_q <= 8'd0;
      duty_b_q <= 8'd0;
      tgt_r_q  <= 8'd0;
      tgt_g_q  <= 8'd0;
      tgt_b_q  <= 8'd0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      tgt_r_q  <= tgt_r_d;
      tgt_g_q  <= tgt_g_d;
      tgt_b_q  <= tgt_b_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

endmodule
